// File: rtl/uart_tx.sv
// UART transmitter with configurable 5-8 data bits, optional odd/even parity,
// one or two stop bits and CTS gating at frame start. 16 ticks per bit.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       cts_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int DIV = CLK_FREQ / (16 * BAUD_RATE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg, state_next;
  logic [TW-1:0]   tick_cnt_reg, tick_cnt_next;
  logic [3:0]      sample_cnt_reg, sample_cnt_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic            stop_cnt_reg, stop_cnt_next;
  logic [7:0]      data_reg;
  logic [1:0]      nbits_reg;
  logic            stop2_reg;
  logic            par_en_reg;
  logic            par_even_reg;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;

  logic            accept;
  logic            tick;
  logic            bit_end;
  logic            last_data;
  logic            last_stop;
  logic [7:0]      sent_bits;
  logic            parity_bit;

  assign accept    = (state_reg == IDLE) && tx_start && !cts_n;
  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign bit_end   = tick && (sample_cnt_reg == 4'd15);
  assign last_data = (bit_cnt_reg == (3'd4 + {1'b0, nbits_reg}));
  assign last_stop = (stop_cnt_reg == stop2_reg);

  // Only the bits actually placed on the line contribute to parity.
  assign sent_bits  = data_reg & (8'hFF >> (2'd3 - nbits_reg));
  assign parity_bit = (^sent_bits) ^ ~par_even_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && last_data) state_next = par_en_reg ? PARITY : STOP;
      PARITY:  if (bit_end) state_next = STOP;
      STOP:    if (bit_end && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tick_cnt_next   = tick_cnt_reg;
    sample_cnt_next = sample_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    stop_cnt_next   = stop_cnt_reg;
    if (accept) begin
      tick_cnt_next   = '0;
      sample_cnt_next = '0;
      bit_cnt_next    = '0;
      stop_cnt_next   = 1'b0;
    end else if (state_reg != IDLE) begin
      tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
      if (tick) sample_cnt_next = sample_cnt_reg + 4'd1;
      if (bit_end && state_reg == DATA)
        bit_cnt_next = last_data ? 3'd0 : bit_cnt_reg + 3'd1;
      if (bit_end && state_reg == STOP)
        stop_cnt_next = ~stop_cnt_reg;
    end
  end

  // Line level is computed from the upcoming state so tx comes straight off a flop.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = (state_next != IDLE);
    done_next = (state_reg == STOP) && (state_next == IDLE);
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = data_reg[bit_cnt_next];
      PARITY:  tx_next = parity_bit;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      data_reg       <= '0;
      nbits_reg      <= '0;
      stop2_reg      <= 1'b0;
      par_en_reg     <= 1'b0;
      par_even_reg   <= 1'b0;
      tx_reg         <= 1'b1;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      tick_cnt_reg   <= tick_cnt_next;
      sample_cnt_reg <= sample_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      stop_cnt_reg   <= stop_cnt_next;
      if (accept) begin
        data_reg     <= tx_data;
        nbits_reg    <= data_bit_num;
        stop2_reg    <= stop_bit_num;
        par_en_reg   <= parity_en;
        par_even_reg <= parity_type;
      end
      tx_reg   <= tx_next;
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule
